// File: rtl/pong_engine.sv
// Two-player LED ping-pong engine: serve, return, speed-up per rally, scoring and match end.
// Single clock; the ball step timer is a plain counter compared against the current period.
module pong_engine #(
    parameter int N_LEDS       = 8,
    parameter int SCORE_W      = 4,
    parameter int WIN_SCORE    = 7,
    parameter int START_PERIOD = 25_000_000,
    parameter int PERIOD_STEP  = 1_000_000,
    parameter int MIN_PERIOD   = 5_000_000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               hit_r,
    input  logic               hit_l,
    output logic [N_LEDS-1:0]  led,
    output logic [SCORE_W-1:0] score_r,
    output logic [SCORE_W-1:0] score_l,
    output logic               game_over,
    output logic               winner
);

    localparam int PW     = $clog2(N_LEDS);
    localparam int TW     = $clog2(START_PERIOD + 1);
    localparam int HALF   = N_LEDS / 2;
    localparam int STEP_C = (PERIOD_STEP > START_PERIOD) ? START_PERIOD : PERIOD_STEP;

    localparam logic [PW-1:0]      POS_MAX = PW'(N_LEDS - 1);
    localparam logic [TW-1:0]      START_V = TW'(START_PERIOD);
    localparam logic [TW-1:0]      MIN_V   = TW'(MIN_PERIOD);
    localparam logic [TW-1:0]      STEP_V  = TW'(STEP_C);
    localparam logic [SCORE_W-1:0] WIN_V   = SCORE_W'(WIN_SCORE);

    typedef enum logic [2:0] {IDLE, MOVE_L, MOVE_R, SHOW, OVER} state_t;

    state_t             state, state_n;
    logic [PW-1:0]      pos, pos_n;
    logic [TW-1:0]      timer, timer_n;
    logic [TW-1:0]      period, period_n, period_dec;
    logic [SCORE_W-1:0] score_r_n, score_l_n, inc_r, inc_l;
    logic               last_l, last_l_n, winner_n;
    logic               hit_r_q, hit_l_q, press_r, press_l, tick;
    logic               serve_r, serve_l, point_r, point_l;

    assign press_r = hit_r & ~hit_r_q;
    assign press_l = hit_l & ~hit_l_q;
    assign tick    = (timer == period - TW'(1));
    assign inc_r   = score_r + SCORE_W'(1);
    assign inc_l   = score_l + SCORE_W'(1);

    // Compare one bit wider so MIN + STEP cannot overflow the period width.
    assign period_dec = ({1'b0, period} >= ({1'b0, MIN_V} + {1'b0, STEP_V}))
                        ? period - STEP_V : MIN_V;

    always_comb begin
        state_n   = state;
        pos_n     = pos;
        timer_n   = timer;
        period_n  = period;
        score_r_n = score_r;
        score_l_n = score_l;
        last_l_n  = last_l;
        winner_n  = winner;
        serve_r   = 1'b0;
        serve_l   = 1'b0;
        point_r   = 1'b0;
        point_l   = 1'b0;

        case (state)
            IDLE: begin
                if (press_r)      serve_r = 1'b1;
                else if (press_l) serve_l = 1'b1;
            end
            MOVE_L: begin
                timer_n = timer + TW'(1);
                if (press_l) begin
                    if (pos == POS_MAX) begin
                        state_n  = MOVE_R;
                        timer_n  = '0;
                        period_n = period_dec;
                    end else begin
                        point_r = 1'b1;
                    end
                end else if (tick) begin
                    timer_n = '0;
                    if (pos == POS_MAX) point_r = 1'b1;
                    else                pos_n   = pos + PW'(1);
                end
            end
            MOVE_R: begin
                timer_n = timer + TW'(1);
                if (press_r) begin
                    if (pos == '0) begin
                        state_n  = MOVE_L;
                        timer_n  = '0;
                        period_n = period_dec;
                    end else begin
                        point_l = 1'b1;
                    end
                end else if (tick) begin
                    timer_n = '0;
                    if (pos == '0) point_l = 1'b1;
                    else           pos_n   = pos - PW'(1);
                end
            end
            SHOW: begin
                if (!last_l && press_r)     serve_r = 1'b1;
                else if (last_l && press_l) serve_l = 1'b1;
            end
            OVER: begin
                if (press_r || press_l) begin
                    score_r_n = '0;
                    score_l_n = '0;
                    state_n   = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase

        if (serve_r || serve_l) begin
            state_n  = serve_r ? MOVE_L : MOVE_R;
            pos_n    = serve_r ? '0 : POS_MAX;
            timer_n  = '0;
            period_n = START_V;
        end

        if (point_r) begin
            score_r_n = inc_r;
            last_l_n  = 1'b0;
            timer_n   = '0;
            if (inc_r == WIN_V) begin
                state_n  = OVER;
                winner_n = 1'b0;
            end else begin
                state_n = SHOW;
            end
        end

        if (point_l) begin
            score_l_n = inc_l;
            last_l_n  = 1'b1;
            timer_n   = '0;
            if (inc_l == WIN_V) begin
                state_n  = OVER;
                winner_n = 1'b1;
            end else begin
                state_n = SHOW;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            pos     <= '0;
            timer   <= '0;
            period  <= START_V;
            score_r <= '0;
            score_l <= '0;
            last_l  <= 1'b0;
            winner  <= 1'b0;
            hit_r_q <= 1'b0;
            hit_l_q <= 1'b0;
        end else begin
            state   <= state_n;
            pos     <= pos_n;
            timer   <= timer_n;
            period  <= period_n;
            score_r <= score_r_n;
            score_l <= score_l_n;
            last_l  <= last_l_n;
            winner  <= winner_n;
            hit_r_q <= hit_r;
            hit_l_q <= hit_l;
        end
    end

    // Display is a pure function of registered state, so it moves on the same edge.
    always_comb begin
        led = '0;
        case (state)
            MOVE_L, MOVE_R: led = N_LEDS'(1) << pos;
            SHOW:           led = {HALF'(score_l), HALF'(score_r)};
            OVER:           led = winner ? {{HALF{1'b1}}, {HALF{1'b0}}}
                                         : {{HALF{1'b0}}, {HALF{1'b1}}};
            default:        led = '0;
        endcase
    end

    assign game_over = (state == OVER);

endmodule

// File: tb/tb_pong_engine.sv
// Bench for pong_engine: game-level model compared every cycle, plus directed literal checks.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_pong_engine;

    localparam int N     = 8;
    localparam int SW    = 4;
    localparam int WIN   = 3;
    localparam int START = 4;
    localparam int STEP  = 1;
    localparam int MINP  = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          hit_r = 1'b0;
    logic          hit_l = 1'b0;
    logic [N-1:0]  led;
    logic [SW-1:0] score_r, score_l;
    logic          game_over, winner;

    int checks   = 0;
    int failures = 0;
    logic cmp_en = 1'b0;

    pong_engine #(
        .N_LEDS(N), .SCORE_W(SW), .WIN_SCORE(WIN),
        .START_PERIOD(START), .PERIOD_STEP(STEP), .MIN_PERIOD(MINP)
    ) dut (
        .clk(clk), .rst(rst), .hit_r(hit_r), .hit_l(hit_l),
        .led(led), .score_r(score_r), .score_l(score_l),
        .game_over(game_over), .winner(winner)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Game model: mode 0 idle, 1 rally, 2 showing score, 3 match over.
    // Ball direction +1 means travelling toward the left player; m_wait counts down to the next step.
    int   m_mode = 0, m_pos = 0, m_dir = 1, m_wait = 0, m_period = START;
    int   m_sr = 0, m_sl = 0, m_last = 0, m_win = 0;
    logic prev_r = 1'b0, prev_l = 1'b0;

    task automatic m_serve(input int who);
        m_mode   = 1;
        m_period = START;
        m_wait   = START;
        m_pos    = (who == 0) ? 0 : N - 1;
        m_dir    = (who == 0) ? 1 : -1;
    endtask

    task automatic m_point(input int who);
        int total;
        if (who == 0) m_sr++;
        else          m_sl++;
        total  = (who == 0) ? m_sr : m_sl;
        m_last = who;
        if (total == WIN) begin
            m_mode = 3;
            m_win  = who;
        end else begin
            m_mode = 2;
        end
    endtask

    function automatic logic [N-1:0] exp_led();
        case (m_mode)
            1:       return N'(1) << m_pos;
            2:       return N'((m_sl << (N / 2)) | m_sr);
            3:       return (m_win == 1) ? 8'hF0 : 8'h0F;
            default: return '0;
        endcase
    endfunction

    always @(posedge clk) begin : model
        logic pr, pl, approach;
        int   far_end, scorer;
        if (rst) begin
            m_mode = 0; m_pos = 0; m_dir = 1; m_wait = 0; m_period = START;
            m_sr = 0; m_sl = 0; m_last = 0; m_win = 0;
            prev_r = 1'b0; prev_l = 1'b0;
        end else begin
            pr = hit_r && !prev_r;
            pl = hit_l && !prev_l;
            case (m_mode)
                0: begin
                    if (pr)      m_serve(0);
                    else if (pl) m_serve(1);
                end
                1: begin
                    approach = (m_dir > 0) ? pl : pr;
                    far_end  = (m_dir > 0) ? N - 1 : 0;
                    scorer   = (m_dir > 0) ? 0 : 1;
                    if (approach) begin
                        if (m_pos == far_end) begin
                            m_dir    = -m_dir;
                            m_period = (m_period - STEP < MINP) ? MINP : m_period - STEP;
                            m_wait   = m_period;
                        end else begin
                            m_point(scorer);
                        end
                    end else begin
                        m_wait--;
                        if (m_wait == 0) begin
                            if (m_pos == far_end) m_point(scorer);
                            else begin
                                m_pos  = m_pos + m_dir;
                                m_wait = m_period;
                            end
                        end
                    end
                end
                2: begin
                    if (m_last == 0 && pr)      m_serve(0);
                    else if (m_last == 1 && pl) m_serve(1);
                end
                default: begin
                    if (pr || pl) begin
                        m_sr = 0; m_sl = 0; m_mode = 0;
                    end
                end
            endcase
            prev_r = hit_r;
            prev_l = hit_l;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("cyc_led", led, exp_led());
            check("cyc_score_r", score_r, m_sr);
            check("cyc_score_l", score_l, m_sl);
            check("cyc_game_over", game_over, (m_mode == 3) ? 1 : 0);
            if (m_mode == 3) check("cyc_winner", winner, m_win);
        end
    end

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press_r();
        hit_r = 1'b1;
        @(negedge clk);
        hit_r = 1'b0;
    endtask

    task automatic press_l();
        hit_l = 1'b1;
        @(negedge clk);
        hit_l = 1'b0;
    endtask

    initial begin
        wait_n(2);
        cmp_en = 1'b1;
        check("rst_led", led, 0);
        check("rst_score_r", score_r, 0);
        check("rst_score_l", score_l, 0);
        check("rst_game_over", game_over, 0);
        check("rst_winner", winner, 0);
        rst = 1'b0;

        // Serve and a full crossing at the start period.
        press_r();
        check("serve_led", led, 8'h01);
        wait_n(4);
        check("first_step", led, 8'h02);
        wait_n(24);
        check("reach_left", led, 8'h80);

        // Returns speed the ball up down to the floor.
        press_l();
        check("ret_hold", led, 8'h80);
        wait_n(3);
        check("ret_step_p3", led, 8'h40);
        wait_n(18);
        check("reach_right", led, 8'h01);
        press_r();
        wait_n(14);
        check("reach_left_p2", led, 8'h80);
        press_l();
        wait_n(1);
        check("floor_hold", led, 8'h80);
        wait_n(1);
        check("floor_step", led, 8'h40);

        // Left misses: point for right, left press ignored in SHOW, right serves.
        wait_n(12);
        check("reach_right2", led, 8'h01);
        press_r();
        wait_n(15);
        check("pre_miss_led", led, 8'h80);
        check("pre_miss_score", score_r, 0);
        wait_n(1);
        check("miss_score_r", score_r, 1);
        check("miss_led", led, 8'h01);
        check("miss_not_over", game_over, 0);
        press_l();
        check("show_ignore_l", led, 8'h01);
        check("show_score_l", score_l, 0);
        press_r();
        check("reserve_led", led, 8'h01);
        wait_n(4);
        check("reserve_step", led, 8'h02);

        // Early left press while held: exactly one point.
        wait_n(8);
        check("early_pos", led, 8'h08);
        hit_l = 1'b1;
        wait_n(1);
        check("early_score_r", score_r, 2);
        check("early_led", led, 8'h02);
        press_r();
        check("held_serve", led, 8'h01);
        wait_n(2);
        check("held_no_retrig", score_r, 2);
        check("held_led", led, 8'h01);
        hit_l = 1'b0;
        wait_n(1);

        // Third point wins the match for right; next press clears without serving.
        press_l();
        check("win_score_r", score_r, 3);
        check("win_over", game_over, 1);
        check("win_winner", winner, 0);
        check("win_led", led, 8'h0F);
        press_r();
        check("clear_score_r", score_r, 0);
        check("clear_led", led, 0);
        check("clear_over", game_over, 0);
        wait_n(2);
        check("clear_no_serve", led, 0);

        // Simultaneous presses in IDLE: right serves.
        hit_r = 1'b1;
        hit_l = 1'b1;
        wait_n(1);
        hit_r = 1'b0;
        hit_l = 1'b0;
        check("simul_led", led, 8'h01);
        wait_n(4);
        check("simul_step", led, 8'h02);
        press_l();
        check("simul_early", score_r, 1);
        press_r();
        wait_n(2);

        // Reset mid-rally.
        rst = 1'b1;
        wait_n(1);
        rst = 1'b0;
        check("mid_rst_led", led, 0);
        check("mid_rst_score_r", score_r, 0);
        check("mid_rst_score_l", score_l, 0);
        check("mid_rst_over", game_over, 0);
        check("mid_rst_winner", winner, 0);
        wait_n(2);
        check("mid_rst_idle", led, 0);

        // Left wins by three early right presses.
        for (int i = 0; i < WIN; i++) begin
            press_l();
            press_r();
        end
        check("lwin_score_l", score_l, 3);
        check("lwin_over", game_over, 1);
        check("lwin_winner", winner, 1);
        check("lwin_led", led, 8'hF0);
        wait_n(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pong_engine.md
# pong_engine

Parametrised two-player LED ping-pong engine, the next-generation replacement for the fixed 8-LED game FSM. It is generalised in LED count, score width, win score and ball speed, and it adds new behaviour: rally speed-up, internal press edge detection, a match-win end state and a single-clock step timer with no derived clock. It sits after the per-player button debouncers and drives the LED bar directly.

## Interface
- `N_LEDS`, 8: LED bar length; even, ≥ 4.
- `SCORE_W`, 4: score counter width; N_LEDS/2 ≥ SCORE_W.
- `WIN_SCORE`, 7: points needed to win the match; 1..2^SCORE_W−1.
- `START_PERIOD`, 25_000_000: clk cycles per ball step at serve; ≥ 2.
- `PERIOD_STEP`, 1_000_000: period decrement per successful return.
- `MIN_PERIOD`, 5_000_000: period floor; 2 ≤ MIN_PERIOD ≤ START_PERIOD.
- `clk` in 1: single clock for all logic.
- `rst` in 1: reset, synchronous and active-high.
- `hit_r` in 1: right player button, debounced level; right end is `led[0]`.
- `hit_l` in 1: left player button, debounced level; left end is `led[N_LEDS-1]`.
- `led` out N_LEDS: LED bar.
- `score_r` out SCORE_W: right player score.
- `score_l` out SCORE_W: left player score.
- `game_over` out 1: high while in OVER.
- `winner` out 1: 0 = right, 1 = left; valid while `game_over` is high.

## Operation
- Press detection: `hit_x` is registered once; a press is `hit_x & ~hit_x_q`. Holding a button produces exactly one press.
- States:
  - IDLE: `led` = 0.
  - MOVE_L: ball travels toward `led[N-1]`.
  - MOVE_R: ball travels toward `led[0]`.
  - SHOW: a point was just scored.
  - OVER: match won.
- Ball position `pos` is 0..N−1. In MOVE_L/MOVE_R, `led` = one-hot(`pos`).
- Step timer: counts 0..`period`−1. A tick occurs when the count equals `period`−1. On a tick, MOVE_L does `pos`+1 and MOVE_R does `pos`−1.
- Serve:
  - In IDLE, either player may serve. On simultaneous presses, right serves.
  - In SHOW, only the player who scored last serves.
  - Right serve: `pos`=0, go to MOVE_L. Left serve: `pos`=N−1, go to MOVE_R.
  - On serve, `period`=START_PERIOD and the timer is cleared.
- Return: in MOVE_L, a left press with `pos`==N−1 reverses the ball to MOVE_R. Symmetric for the right player in MOVE_R.
  - On return, `pos` is unchanged and the timer is cleared.
  - `period` = max(`period`−PERIOD_STEP, MIN_PERIOD).
- Early: in MOVE_L, a left press with `pos`≠N−1 scores a point for right. Symmetric for the right player.
- Miss: in MOVE_L, a tick with `pos`==N−1 and no left press that cycle scores a point for right. Symmetric for the right player.
- Presses by the player the ball is travelling away from are ignored.
- Point scored:
  - The scorer's score is incremented.
  - If the new score equals WIN_SCORE, go to OVER with `winner` set. Otherwise go to SHOW.
  - Scorer is remembered for the next serve.
- SHOW display: `led[N-1:N/2]` = `score_l` and `led[N/2-1:0]` = `score_r`, each zero-extended.
- OVER display: the winner's half of `led` is all ones and the other half is 0.
  - Any press clears both scores and goes to IDLE.
  - That press does not also serve.
- Scores never exceed WIN_SCORE. There is no wrap.

## Timing
- Reset values: state IDLE, `led`=0, `score_r`=`score_l`=0, `game_over`=0, `winner`=0, `period`=START_PERIOD, timer=0, press registers=0.
- `rst` mid-rally takes effect on the next clk edge and discards the rally and scores.
- Press latency: a button rising at edge k is seen as a press at edge k+1. All outputs are registered and update at edge k+1.
- After a serve, the first move happens START_PERIOD cycles later. A ball crosses from end to end in (N−1)·`period` cycles.
- Same-cycle tick and valid return at the end LED: the return wins.
- Same-cycle presses by both players in MOVE_x: only the player the ball approaches is evaluated.
- `period` resets to START_PERIOD on every serve and never goes below MIN_PERIOD.

## Test plan
Parameters for all scenarios: N_LEDS=8, START_PERIOD=4, PERIOD_STEP=1, MIN_PERIOD=2, WIN_SCORE=3.

- Reset, then right press → `led`=0x01; 4 cycles later `led`=0x02; 28 cycles after serve `led`=0x80.
- Ball at 0x80, left press → state MOVE_R; next move after 3 cycles to 0x40; a second full return gives period 2, and a third return stays at 2.
- Ball at 0x80, no left press → on the tick `score_r`=1, `led`=0x01 (SHOW); a left press is ignored; a right press serves with `led`=0x01.
- Right serve, left presses while `led`=0x08 → `score_r`=1, SHOW; a held `hit_l` does not re-trigger.
- Right scores 3 times → `game_over`=1, `winner`=0, `led`=0x0F; next press → scores 0, `led`=0, IDLE.
- Simultaneous presses in IDLE → right serves, `led`=0x01; `rst` pulsed mid-rally → all outputs at their reset values after 1 edge.
